// File: rtl/prod_shift_truncate.sv
// Word-serial right-shift-and-truncate stage for Barrett reduction: emits product bits [SHIFT_BITS +: OUT_WORDS*W].
// Optional sticky protocol checking is enabled with `define PROD_SHIFT_ERR_CHECK_EN.
module prod_shift_truncate #(
  parameter int REGISTER_SIZE = 32,
  parameter int BITS_IN_NUM   = 4096,
  parameter int SHIFT_BITS    = 4064,
  parameter int OUT_WORDS     = 128
) (
  input  logic                     clk_in,
  input  logic                     rst_in,
  input  logic [REGISTER_SIZE-1:0] data_in,
  input  logic                     valid_in,
  input  logic                     final_in,
  output logic                     ready_out,
  output logic [REGISTER_SIZE-1:0] data_out,
  output logic                     valid_out,
  input  logic                     ready_in,
  output logic                     final_out,
  output logic                     error_out
);

  localparam int W        = REGISTER_SIZE;
  localparam int IN_WORDS = 2 * BITS_IN_NUM / W;
  localparam int WORD_OFF = SHIFT_BITS / W;
  localparam int BIT_OFF  = SHIFT_BITS % W;
  localparam int LAG      = (BIT_OFF != 0) ? 1 : 0;
  localparam int IDX_W    = $clog2(IN_WORDS + OUT_WORDS + 2) + 1;
  localparam int CNT_W    = $clog2(OUT_WORDS + 1);
  localparam int AW       = (OUT_WORDS > 1) ? $clog2(OUT_WORDS) : 1;

  localparam logic [IDX_W-1:0] FIRST_IDX = IDX_W'(WORD_OFF + LAG);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(WORD_OFF + OUT_WORDS - 1 + LAG);
  localparam logic [IDX_W-1:0] IN_LAST   = IDX_W'(IN_WORDS - 1);
  localparam logic [CNT_W-1:0] OUT_CNT   = CNT_W'(OUT_WORDS);
  localparam logic [CNT_W-1:0] OUT_LAST  = CNT_W'(OUT_WORDS - 1);

  typedef enum logic [1:0] {IDLE, COLLECT, FLUSH, DRAIN} state_t;

  state_t           state;
  logic [IDX_W-1:0] idx;
  logic [IDX_W-1:0] cur_idx;
  logic             cur_vld;
  logic [W-1:0]     cur_word;
  logic [W-1:0]     prev_word;
  logic [CNT_W-1:0] wr_cnt;
  logic [CNT_W-1:0] rd_cnt;
  logic [W-1:0]     mem [OUT_WORDS];

  logic         accept, flush_push, push, frame_end;
  logic         wr_en, load, take, drain_done;
  logic [W-1:0] push_word, wr_word;

  always_comb begin
    accept     = valid_in && ((state == IDLE && ready_out) || state == COLLECT);
    flush_push = (state == FLUSH) && (idx <= LAST_IDX);
    push       = accept || flush_push;
    push_word  = accept ? data_in : '0;
    frame_end  = accept && (final_in || idx == IN_LAST);
    wr_en      = cur_vld && (cur_idx >= FIRST_IDX) && (cur_idx <= LAST_IDX);
    if (BIT_OFF == 0)
      wr_word = cur_word;
    else
      wr_word = W'({cur_word, prev_word} >> BIT_OFF);
    load       = (rd_cnt < wr_cnt) && (!valid_out || ready_in);
    take       = valid_out && ready_in;
    drain_done = (state == DRAIN) && (rd_cnt == OUT_CNT) && (!valid_out || ready_in);
  end

  // Frame sequencing; FLUSH keeps feeding zero words until every output word is produced.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state     <= IDLE;
      idx       <= '0;
      ready_out <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          ready_out <= 1'b1;
          if (accept) begin
            idx       <= idx + 1'b1;
            ready_out <= 1'b0;
            state     <= frame_end ? FLUSH : COLLECT;
          end
        end
        COLLECT: begin
          if (accept) begin
            idx <= idx + 1'b1;
            if (frame_end) state <= FLUSH;
          end
        end
        FLUSH: begin
          if (flush_push)
            idx <= idx + 1'b1;
          else if (wr_cnt == OUT_CNT)
            state <= DRAIN;
        end
        DRAIN: begin
          if (drain_done) begin
            state     <= IDLE;
            idx       <= '0;
            ready_out <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      cur_word  <= '0;
      prev_word <= '0;
      cur_idx   <= '0;
      cur_vld   <= 1'b0;
    end else begin
      cur_vld <= push;
      if (push) begin
        prev_word <= cur_word;
        cur_word  <= push_word;
        cur_idx   <= idx;
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (wr_en) mem[wr_cnt[AW-1:0]] <= wr_word;
  end

  // Counters double as buffer pointers since a frame never holds more than OUT_WORDS words.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      wr_cnt    <= '0;
      rd_cnt    <= '0;
      valid_out <= 1'b0;
      data_out  <= '0;
      final_out <= 1'b0;
    end else begin
      if (wr_en) wr_cnt <= wr_cnt + 1'b1;
      if (load) begin
        data_out  <= mem[rd_cnt[AW-1:0]];
        final_out <= (rd_cnt == OUT_LAST);
        valid_out <= 1'b1;
        rd_cnt    <= rd_cnt + 1'b1;
      end else if (take) begin
        valid_out <= 1'b0;
        final_out <= 1'b0;
      end
      if (drain_done) begin
        wr_cnt <= '0;
        rd_cnt <= '0;
      end
    end
  end

`ifdef PROD_SHIFT_ERR_CHECK_EN
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in)
      error_out <= 1'b0;
    else if ((valid_in && (state == FLUSH || state == DRAIN)) ||
             (accept && final_in && idx != IN_LAST))
      error_out <= 1'b1;
  end
`else
  assign error_out = 1'b0;
`endif

endmodule

// File: tb/tb_prod_shift_truncate.sv
// Directed bench for prod_shift_truncate with two instances (SHIFT_BITS=20 and 16) fed the same frames.
// Error expectations follow PROD_SHIFT_ERR_CHECK_EN.
module tb_prod_shift_truncate;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] data_in;
  logic       valid_in, final_in, ready_in;
  logic       ready_a, valid_a, final_a, error_a;
  logic       ready_b, valid_b, final_b, error_b;
  logic [7:0] data_a, data_b;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int word3_edge = 0;
  int first_valid_a = -1;
  logic [8:0] q_a[$];
  logic [8:0] q_b[$];
  logic [7:0] frame [8] = '{8'h10, 8'h32, 8'h54, 8'h76, 8'h98, 8'hBA, 8'hDC, 8'hFE};

`ifdef PROD_SHIFT_ERR_CHECK_EN
  localparam logic ERR_EXP = 1'b1;
`else
  localparam logic ERR_EXP = 1'b0;
`endif

  prod_shift_truncate #(.REGISTER_SIZE(8), .BITS_IN_NUM(32), .SHIFT_BITS(20), .OUT_WORDS(4)) dut_a (
    .clk_in(clk), .rst_in(rst_n), .data_in(data_in), .valid_in(valid_in), .final_in(final_in),
    .ready_out(ready_a), .data_out(data_a), .valid_out(valid_a), .ready_in(ready_in),
    .final_out(final_a), .error_out(error_a));

  prod_shift_truncate #(.REGISTER_SIZE(8), .BITS_IN_NUM(32), .SHIFT_BITS(16), .OUT_WORDS(4)) dut_b (
    .clk_in(clk), .rst_in(rst_n), .data_in(data_in), .valid_in(valid_in), .final_in(final_in),
    .ready_out(ready_b), .data_out(data_b), .valid_out(valid_b), .ready_in(ready_in),
    .final_out(final_b), .error_out(error_b));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Record every output transfer; sampled mid-cycle, the transfer completes on the next rising edge.
  always @(negedge clk) begin
    if (valid_a && ready_in) q_a.push_back({final_a, data_a});
    if (valid_b && ready_in) q_b.push_back({final_b, data_b});
    if (valid_a && first_valid_a < 0) first_valid_a = cyc;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    if (observed !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic waitReady(input string tag);
    int t = 0;
    while (!(ready_a && ready_b) && t < 100) begin
      @(posedge clk); #1;
      t++;
    end
    checkOutput({tag, "_ready_a"}, {31'b0, ready_a}, 32'd1);
    checkOutput({tag, "_ready_b"}, {31'b0, ready_b}, 32'd1);
  endtask

  task automatic applyStimulus(input int n_words, input logic final_last);
    int t = 0;
    while (!(ready_a && ready_b) && t < 100) begin
      @(posedge clk); #1;
      t++;
    end
    if (!(ready_a && ready_b)) checkOutput("start_ready", {31'b0, ready_a & ready_b}, 32'd1);
    for (int k = 0; k < n_words; k++) begin
      valid_in = 1'b1;
      data_in  = frame[k];
      final_in = final_last && (k == n_words - 1);
      if (k == 3) word3_edge = cyc + 1;
      @(posedge clk); #1;
    end
    valid_in = 1'b0;
    final_in = 1'b0;
    data_in  = 8'h00;
  endtask

  task automatic finishFrame(input string tag, input logic [31:0] a_words, input logic [31:0] b_words);
    int t = 0;
    logic [31:0] exp_a, exp_b;
    while ((q_a.size() < 4 || q_b.size() < 4) && t < 200) begin
      @(posedge clk); #1;
      t++;
    end
    waitReady(tag);
    checkOutput({tag, "_count_a"}, q_a.size(), 32'd4);
    checkOutput({tag, "_count_b"}, q_b.size(), 32'd4);
    for (int i = 0; i < 4; i++) begin
      exp_a = {23'b0, (i == 3), a_words[8*i +: 8]};
      exp_b = {23'b0, (i == 3), b_words[8*i +: 8]};
      checkOutput($sformatf("%s_a_w%0d", tag, i), (i < q_a.size()) ? {23'b0, q_a[i]} : 32'hFFFF_FFFF, exp_a);
      checkOutput($sformatf("%s_b_w%0d", tag, i), (i < q_b.size()) ? {23'b0, q_b[i]} : 32'hFFFF_FFFF, exp_b);
    end
  endtask

  task automatic clearQueues();
    q_a.delete();
    q_b.delete();
    first_valid_a = -1;
  endtask

  initial begin
    rst_n = 1'b0; data_in = 8'h00; valid_in = 1'b0; final_in = 1'b0; ready_in = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_ready", {31'b0, ready_a}, 32'd0);
    checkOutput("rst_valid", {31'b0, valid_a}, 32'd0);
    checkOutput("rst_data", {24'b0, data_a}, 32'd0);
    checkOutput("rst_final", {31'b0, final_a}, 32'd0);
    checkOutput("rst_error", {31'b0, error_a}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    checkOutput("idle_ready", {31'b0, ready_a}, 32'd1);

    $display("[TB] test 1/2: full frame, shifts 20 and 16");
    clearQueues();
    applyStimulus(8, 1'b1);
    finishFrame("t1", 32'hCBA98765, 32'hBA987654);
    checkOutput("t1_latency", first_valid_a - word3_edge, 32'd2);
    checkOutput("t1_error", {31'b0, error_a}, 32'd0);

    $display("[TB] test 3: downstream stalled");
    clearQueues();
    ready_in = 1'b0;
    applyStimulus(8, 1'b1);
    @(posedge clk); #1;
    checkOutput("t3_hold_data0", {24'b0, data_a}, 32'h65);
    repeat (11) @(posedge clk);
    #1;
    checkOutput("t3_hold_valid", {31'b0, valid_a}, 32'd1);
    checkOutput("t3_hold_data", {24'b0, data_a}, 32'h65);
    checkOutput("t3_hold_final", {31'b0, final_a}, 32'd0);
    ready_in = 1'b1;
    finishFrame("t3", 32'hCBA98765, 32'hBA987654);

    $display("[TB] test 4: short frame, final on word 5");
    clearQueues();
    applyStimulus(6, 1'b1);
    finishFrame("t4", 32'h0BA98765, 32'hBA987654);
    checkOutput("t4_error_a", {31'b0, error_a}, {31'b0, ERR_EXP});
    checkOutput("t4_error_b", {31'b0, error_b}, {31'b0, ERR_EXP});

    $display("[TB] test 5: reset mid-frame");
    clearQueues();
    applyStimulus(5, 1'b0);
    rst_n = 1'b0;
    #1;
    checkOutput("t5_valid_a", {31'b0, valid_a}, 32'd0);
    checkOutput("t5_valid_b", {31'b0, valid_b}, 32'd0);
    checkOutput("t5_data_b", {24'b0, data_b}, 32'd0);
    checkOutput("t5_ready_a", {31'b0, ready_a}, 32'd0);
    checkOutput("t5_error_a", {31'b0, error_a}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    clearQueues();
    @(posedge clk); #1;
    applyStimulus(8, 1'b1);
    finishFrame("t5", 32'hCBA98765, 32'hBA987654);
    checkOutput("t5_latency", first_valid_a - word3_edge, 32'd2);

    $display("[TB] test 6: input pulse while draining");
    clearQueues();
    ready_in = 1'b0;
    applyStimulus(8, 1'b1);
    repeat (4) @(posedge clk);
    #1;
    valid_in = 1'b1; data_in = 8'hFF; final_in = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    valid_in = 1'b0; data_in = 8'h00; final_in = 1'b0;
    ready_in = 1'b1;
    finishFrame("t6", 32'hCBA98765, 32'hBA987654);
    checkOutput("t6_error_a", {31'b0, error_a}, {31'b0, ERR_EXP});

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
